// File: rtl/pattern_sequencer_if.sv
// Control/status bundle for pattern_sequencer: pattern writes, window/rate setup,
// start/stop requests and the registered pattern output with its status flags.
interface pattern_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DIV_WIDTH  = 32
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DIV_WIDTH-1:0]  divisor;
    logic [ADDR_WIDTH-1:0] first_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [1:0]            mode;
    logic                  start;
    logic                  stop;
    logic [DATA_WIDTH-1:0] pattern_out;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  busy;
    logic                  step;
    logic                  done;

    modport master (
        output wr_en, wr_addr, wr_data, divisor, first_addr, last_addr, mode, start, stop,
        input  pattern_out, cur_addr, busy, step, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, divisor, first_addr, last_addr, mode, start, stop,
        output pattern_out, cur_addr, busy, step, done
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Steps through a writable pattern memory over an address window at a programmable rate.
// Define PATTERN_SEQ_BLANK_EN to force pattern_out to zero while stopped or finished.
module pattern_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DIV_WIDTH  = 32
) (
    input logic             clk,
    input logic             reset,
    pattern_sequencer_if.slave bus
);
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [ADDR_WIDTH-1:0] first_q, last_q;
    logic [1:0]            mode_q;
    logic                  dir_up, dir_up_nxt;
    logic [DIV_WIDTH-1:0]  count, count_nxt;
    logic                  load_pending, load_nxt;
    logic                  tick, stop_accepted, start_accepted, done_int;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] pattern_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic                  step_q;

    // >= rather than == so a divisor lowered mid-run takes effect at once
    assign tick           = (state == RUN) && (count >= bus.divisor);
    assign stop_accepted  = (state == RUN) && bus.stop;
    assign start_accepted = bus.start && !bus.stop;

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        dir_up_nxt = dir_up;
        count_nxt  = count;
        load_nxt   = 1'b0;
        done_int   = 1'b0;
        if (bus.stop) begin
            if (state == RUN)
                state_nxt = IDLE;
        end else if (bus.start) begin
            state_nxt  = RUN;
            addr_nxt   = bus.first_addr;
            count_nxt  = '0;
            dir_up_nxt = 1'b1;
            load_nxt   = 1'b1;
        end else if (state == RUN) begin
            if (tick) begin
                count_nxt = '0;
                load_nxt  = 1'b1;
                case (mode_q)
                    MODE_ONESHOT: begin
                        if (addr == last_q) begin
                            done_int  = 1'b1;
                            state_nxt = DONE;
                            load_nxt  = 1'b0;
                        end else begin
                            addr_nxt = addr + 1'b1;
                        end
                    end
                    MODE_PINGPONG: begin
                        // a single-entry window parks on that entry but keeps stepping
                        if (first_q != last_q) begin
                            if (dir_up) begin
                                if (addr == last_q) begin
                                    dir_up_nxt = 1'b0;
                                    addr_nxt   = addr - 1'b1;
                                end else begin
                                    addr_nxt = addr + 1'b1;
                                end
                            end else begin
                                if (addr == first_q) begin
                                    dir_up_nxt = 1'b1;
                                    addr_nxt   = addr + 1'b1;
                                end else begin
                                    addr_nxt = addr - 1'b1;
                                end
                            end
                        end
                    end
                    default: addr_nxt = (addr == last_q) ? first_q : addr + 1'b1;
                endcase
            end else begin
                count_nxt = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en)
            mem[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            first_q      <= '0;
            last_q       <= '0;
            mode_q       <= '0;
            dir_up       <= 1'b1;
            count        <= '0;
            load_pending <= 1'b0;
            pattern_q    <= '0;
            cur_addr_q   <= '0;
            step_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            addr         <= addr_nxt;
            dir_up       <= dir_up_nxt;
            count        <= count_nxt;
            load_pending <= load_nxt;
            if (start_accepted) begin
                first_q <= bus.first_addr;
                last_q  <= bus.last_addr;
                mode_q  <= bus.mode;
            end
            // an in-flight read still lands after stop, but silently
            step_q <= load_pending && !stop_accepted;
            if (load_pending)
                cur_addr_q <= addr;
`ifdef PATTERN_SEQ_BLANK_EN
            if (load_pending)
                pattern_q <= mem[addr];
            else if (state != RUN)
                pattern_q <= '0;
`else
            if (load_pending)
                pattern_q <= mem[addr];
`endif
        end
    end

    assign bus.pattern_out = pattern_q;
    assign bus.cur_addr    = cur_addr_q;
    assign bus.busy        = (state == RUN);
    assign bus.step        = step_q;
    assign bus.done        = done_int;
endmodule
